channel_mux_arb: RTL and testbench

CHANNEL_MUX_ARB -- requirements
Module: channel_mux_arb

---
 rtl/channel_mux_arb.sv | 91 +++++++++
 tb/tb_channel_mux_arb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/channel_mux_arb.sv
// channel_mux_arb: NCH-to-1 channel multiplexer with direct or round-robin
// selection, feeding a single-entry registered output stage with full
// throughput under dout_ready backpressure.
module channel_mux_arb #(
    parameter int WIDTH = 14,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [NCH*WIDTH-1:0]  din,
    input  logic [NCH-1:0]        din_valid,
    output logic [NCH-1:0]        din_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [SELW-1:0]       dout_ch
);

    logic [SELW-1:0]  ptr;
    logic             ld;
    logic             grant_found;
    logic [SELW-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;
    int               rr_idx;

    // The output register may accept a new word when empty or being drained.
    assign ld = !dout_valid || dout_ready;

    // Choose a channel: sel in direct mode, otherwise search from ptr+1 with
    // wrap; walking the search order backwards lets the nearest hit win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        rr_idx      = 0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && din_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SELW'(i);
                    grant_data  = din[i*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int k = NCH; k >= 1; k--) begin
                rr_idx = (int'(ptr) + k) % NCH;
                if (din_valid[rr_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = SELW'(rr_idx);
                    grant_data  = din[rr_idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    // One-hot accept strobe, suppressed during reset and while stalled.
    always_comb begin
        din_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            din_ready[i] = rst_n && ld && grant_found && (grant_idx == SELW'(i));
        end
    end

    assign xfer = |din_ready;

    // Output register and round-robin pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
            ptr        <= SELW'(NCH - 1);
        end else if (ld) begin
            if (xfer) begin
                dout       <= grant_data;
                dout_ch    <= grant_idx;
                dout_valid <= 1'b1;
                if (mode) begin
                    ptr <= grant_idx;
                end
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_channel_mux_arb.sv
// tb_channel_mux_arb: table-driven directed test of channel_mux_arb (NCH=8)
// plus a short hand sequence on a second NCH=6 instance for out-of-range sel.
module tb_channel_mux_arb;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  valid;
        logic        dready;
        logic [7:0]  exp_ready;
        logic        exp_dv;
        logic [2:0]  exp_ch;
        logic [13:0] exp_dout;
    } vec_t;

    localparam logic [13:0] CH_DATA [8] = '{14'h0010, 14'h0111, 14'h0155, 14'h0333,
                                            14'h0444, 14'h1ABC, 14'h0666, 14'h0777};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic [111:0] din;
    logic [7:0]  din_valid;
    logic [7:0]  din_ready;
    logic [13:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  dout_ch;

    logic        mode6;
    logic [2:0]  sel6;
    logic [83:0] din6;
    logic [5:0]  din_valid6;
    logic [5:0]  din_ready6;
    logic [13:0] dout6;
    logic        dout_valid6;
    logic        dout_ready6;
    logic [2:0]  dout_ch6;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    assign din  = {CH_DATA[7], CH_DATA[6], CH_DATA[5], CH_DATA[4],
                   CH_DATA[3], CH_DATA[2], CH_DATA[1], CH_DATA[0]};
    assign din6 = {CH_DATA[5], CH_DATA[4], CH_DATA[3], CH_DATA[2], CH_DATA[1], CH_DATA[0]};

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    channel_mux_arb #(.WIDTH(14), .NCH(8), .SELW(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_ch(dout_ch)
    );

    channel_mux_arb #(.WIDTH(14), .NCH(6), .SELW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode6), .sel(sel6), .din(din6),
        .din_valid(din_valid6), .din_ready(din_ready6), .dout(dout6),
        .dout_valid(dout_valid6), .dout_ready(dout_ready6), .dout_ch(dout_ch6)
    );

    function automatic vec_t mkVec(logic r, logic m, logic [2:0] s, logic [7:0] v, logic dr,
                                   logic [7:0] er, logic edv, logic [2:0] ech, logic [13:0] ed);
        vec_t x;
        x.rst_n = r; x.mode = m; x.sel = s; x.valid = v; x.dready = dr;
        x.exp_ready = er; x.exp_dv = edv; x.exp_ch = ech; x.exp_dout = ed;
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one vector at the falling edge, check the combinational strobe,
    // then check the registered outputs just after the rising edge.
    task automatic applyStimulus(input vec_t v, input int n);
        @(negedge clk);
        rst_n      = v.rst_n;
        mode       = v.mode;
        sel        = v.sel;
        din_valid  = v.valid;
        dout_ready = v.dready;
        #1;
        checkOutput($sformatf("v%0d din_ready", n), 32'(din_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d dout_valid", n), 32'(dout_valid), 32'(v.exp_dv));
        checkOutput($sformatf("v%0d dout_ch", n), 32'(dout_ch), 32'(v.exp_ch));
        checkOutput($sformatf("v%0d dout", n), 32'(dout), 32'(v.exp_dout));
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel = '0; din_valid = '0; dout_ready = 1'b0;
        mode6 = 1'b0; sel6 = '0; din_valid6 = '0; dout_ready6 = 1'b0;

        // Reset, then direct mode sel=5
        vecs.push_back(mkVec(0, 0, 5, 8'h20, 1, 8'h00, 0, 0, 14'h0000));
        vecs.push_back(mkVec(1, 0, 5, 8'h20, 1, 8'h20, 1, 5, 14'h1ABC));
        vecs.push_back(mkVec(1, 0, 5, 8'h00, 1, 8'h00, 0, 5, 14'h1ABC));
        // Reset, then round-robin over all eight channels for 10 cycles
        vecs.push_back(mkVec(0, 1, 0, 8'hFF, 1, 8'h00, 0, 0, 14'h0000));
        for (int k = 0; k < 10; k++) begin
            vecs.push_back(mkVec(1, 1, 0, 8'hFF, 1, 8'h01 << (k % 8), 1, 3'(k % 8), CH_DATA[k % 8]));
        end
        // ptr=1: channels 0 and 7 alternate starting with 7
        vecs.push_back(mkVec(1, 1, 0, 8'h81, 1, 8'h80, 1, 7, CH_DATA[7]));
        vecs.push_back(mkVec(1, 1, 0, 8'h81, 1, 8'h01, 1, 0, CH_DATA[0]));
        vecs.push_back(mkVec(1, 1, 0, 8'h81, 1, 8'h80, 1, 7, CH_DATA[7]));
        vecs.push_back(mkVec(1, 1, 0, 8'h81, 1, 8'h01, 1, 0, CH_DATA[0]));
        // Direct mode stall then release; ptr stays at 0
        vecs.push_back(mkVec(1, 0, 3, 8'h08, 0, 8'h00, 1, 0, CH_DATA[0]));
        vecs.push_back(mkVec(1, 0, 3, 8'h08, 1, 8'h08, 1, 3, CH_DATA[3]));
        // Back to round-robin from ptr=0
        vecs.push_back(mkVec(1, 1, 0, 8'h06, 1, 8'h02, 1, 1, CH_DATA[1]));
        vecs.push_back(mkVec(1, 1, 0, 8'h06, 1, 8'h04, 1, 2, CH_DATA[2]));
        // Backpressure: ch2 word held 3 cycles, then ch3 loads with no bubble
        vecs.push_back(mkVec(1, 0, 2, 8'h04, 1, 8'h04, 1, 2, 14'h0155));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mkVec(1, 0, 3, 8'h08, 0, 8'h00, 1, 2, 14'h0155));
        end
        vecs.push_back(mkVec(1, 0, 3, 8'h08, 1, 8'h08, 1, 3, 14'h0333));
        // Reset mid-stall discards the word; round-robin restarts from ptr=NCH-1
        vecs.push_back(mkVec(1, 0, 4, 8'h10, 1, 8'h10, 1, 4, 14'h0444));
        vecs.push_back(mkVec(1, 0, 4, 8'h10, 0, 8'h00, 1, 4, 14'h0444));
        vecs.push_back(mkVec(0, 0, 4, 8'h10, 0, 8'h00, 0, 0, 14'h0000));
        vecs.push_back(mkVec(1, 1, 0, 8'h30, 1, 8'h10, 1, 4, 14'h0444));
        vecs.push_back(mkVec(1, 1, 0, 8'h30, 1, 8'h20, 1, 5, 14'h1ABC));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // NCH=6 instance: load via sel=2, then sel=7 selects nothing
        @(negedge clk);
        din_valid = '0;
        mode6 = 1'b0; sel6 = 3'd2; din_valid6 = 6'h3F; dout_ready6 = 1'b1;
        #1;
        checkOutput("n6 din_ready sel2", 32'(din_ready6), 32'h04);
        @(posedge clk);
        #1;
        checkOutput("n6 dout_valid load", 32'(dout_valid6), 32'h1);
        checkOutput("n6 dout load", 32'(dout6), 32'h0155);
        @(negedge clk);
        sel6 = 3'd7;
        #1;
        checkOutput("n6 din_ready sel7", 32'(din_ready6), 32'h00);
        @(posedge clk);
        #1;
        checkOutput("n6 dout_valid drop", 32'(dout_valid6), 32'h0);
        checkOutput("n6 dout hold", 32'(dout6), 32'h0155);
        checkOutput("n6 dout_ch hold", 32'(dout_ch6), 32'h2);
        @(negedge clk);
        #1;
        checkOutput("n6 din_ready idle", 32'(din_ready6), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
